// File: rtl/hdmi_timing_pkg.sv
// Shared constants for the HDMI timing generator: counter width and colour-bar palette.
package hdmi_timing_pkg;

    localparam int CNT_W = 12;

    // Left-to-right bar order, {r, g, b}
    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/hdmi_pattern_gen.sv
// Test-pattern source: colour bars with HDMI_TIMING_GEN_BARS_EN, grey ramp r=g=b=h[7:0] otherwise.
module hdmi_pattern_gen
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] h,
    input  logic [CNT_W-1:0] v,
    input  logic             active,
    output logic [23:0]      rgb
);

`ifdef HDMI_TIMING_GEN_BARS_EN
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

    logic [CNT_W-1:0] bar_px_q;
    logic [CNT_W-1:0] bar_px;
    logic [2:0]       bar_idx_q;
    logic [2:0]       bar_idx;

    // h is either 0 or one past the previous cycle's h, so the bar position
    // is the registered one stepped by a single pixel.
    always_comb begin
        bar_px  = '0;
        bar_idx = '0;
        if (h != '0) begin
            if (bar_px_q == BAR_LAST) begin
                bar_px  = '0;
                bar_idx = bar_idx_q + 3'd1;
            end else begin
                bar_px  = bar_px_q + CNT_W'(1);
                bar_idx = bar_idx_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_px_q  <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_px_q  <= bar_px;
            bar_idx_q <= bar_idx;
        end
    end

    assign rgb = active ? BAR_RGB[bar_idx] : 24'h000000;

    logic unused_v;
    assign unused_v = ^v;
`else
    assign rgb = active ? {3{h[7:0]}} : 24'h000000;

    logic unused_bits;
    assign unused_bits = ^{clk, rst, v, h[CNT_W-1:8]};
`endif

endmodule

// File: rtl/hdmi_timing_gen.sv
// HDMI video timing source with registered sync/DE, coordinates and built-in test pattern.
// Build option: HDMI_TIMING_GEN_BARS_EN selects colour bars instead of the grey ramp.
module hdmi_timing_gen
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = 64,
    parameter int H_FP     = 4,
    parameter int H_SYNC   = 8,
    parameter int H_BP     = 4,
    parameter int V_ACTIVE = 48,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 2,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic             hdmi_clk,
    input  logic             hdmi_rst,
    input  logic             enable,
    output logic             hdmi_de,
    output logic             hdmi_hs,
    output logic             hdmi_vs,
    output logic [7:0]       hdmi_r,
    output logic [7:0]       hdmi_g,
    output logic [7:0]       hdmi_b,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             de_c;
    logic             hs_c;
    logic             vs_c;
    logic [23:0]      rgb_c;

    assign de_c = (h < H_ACT) && (v < V_ACT);
    assign hs_c = (h >= HS_START) && (h < HS_END);
    assign vs_c = (v >= VS_START) && (v < VS_END);

    hdmi_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern (
        .clk    (hdmi_clk),
        .rst    (hdmi_rst),
        .h      (h),
        .v      (v),
        .active (de_c),
        .rgb    (rgb_c)
    );

    // Counter state is decoded and registered in the same edge that advances it,
    // so the outputs always describe the previous counter position.
    always_ff @(posedge hdmi_clk or posedge hdmi_rst) begin
        if (hdmi_rst || !enable) begin
            h           <= '0;
            v           <= '0;
            hdmi_de     <= 1'b0;
            hdmi_hs     <= !HS_POL;
            hdmi_vs     <= !VS_POL;
            hdmi_r      <= '0;
            hdmi_g      <= '0;
            hdmi_b      <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            h <= (h == H_LAST) ? '0 : h + CNT_W'(1);
            if (h == H_LAST) begin
                v <= (v == V_LAST) ? '0 : v + CNT_W'(1);
            end
            hdmi_de     <= de_c;
            hdmi_hs     <= hs_c ? HS_POL : !HS_POL;
            hdmi_vs     <= vs_c ? VS_POL : !VS_POL;
            hdmi_r      <= rgb_c[23:16];
            hdmi_g      <= rgb_c[15:8];
            hdmi_b      <= rgb_c[7:0];
            pix_x       <= h;
            pix_y       <= v;
            frame_start <= (h == '0) && (v == '0);
        end
    end

endmodule
